cdb_broadcast_arbiter: RTL and testbench
========================================

// Module: cdb_broadcast_arbiter
// PURPOSE
//  Transmit side of the common data bus. Collects completed results (ROB tag + value) from N_FU
//  functional units and buffers each unit's results in a small per-unit FIFO. Picks one FIFO per
//  cycle by round-robin and drives robEntry/result/validBroadcast for one cycle.
//  Every reservation-station entry and the ROB snoop this broadcast.
// PARAMETERS
//  N_FU   4   number of functional-unit result sources
//  WIDTH  31  MSB index of result value (value is WIDTH+1 bits)
//  ROB    2   MSB index of ROB tag (tag is ROB+1 bits)
//  DEPTH  2   entries per per-FU result FIFO (power of 2, >=2)
// PORTS
//  clk            in   1                 rising-edge clock
//  globalReset    in   1                 synchronous, active-high reset
//  clear          in   1                 pipeline-flush request
//  validCommit    in   1                 qualifies clear; flush = clear & validCommit
//  fuValid        in   N_FU              FU i presents a result this cycle
//  fuReady        out  N_FU              FU i result FIFO can accept
//  fuRob          in   N_FU*(ROB+1)      packed ROB tags, FU i at slice i
//  fuResult       in   N_FU*(WIDTH+1)    packed results, FU i at slice i
//  validBroadcast out  1                 bus carries a valid result
//  robEntry       out  ROB+1             broadcast ROB tag
//  result         out  WIDTH+1           broadcast value (signed)
//  grantIdx       out  $clog2(N_FU)      source FU of the current broadcast
// BEHAVIOUR
//  - One clock (clk). Reset is synchronous and active-high (globalReset); sampled only at posedge clk.
//  - Reset values: validBroadcast=0, robEntry=0, result=0, grantIdx=0, all FIFOs empty,
//    fuReady all 1 from the first cycle after reset, RR pointer=0.
//  - Input handshake: push FU i when fuValid[i] & fuReady[i].
//    fuReady[i] = !full[i], registered-state-derived only; no combinational path from fuValid.
//    An FU holds its result and tag stable while valid & !ready.
//  - Arbitration: requesters = non-empty FIFOs.
//    Grant the first requester at or after rrPtr (mod N_FU), pop its head.
//    Register {tag,value} into robEntry/result and set validBroadcast=1 at the same edge.
//    Then rrPtr <= grant+1 (mod N_FU). With no requester, validBroadcast <= 0;
//    robEntry/result hold their last values and rrPtr is unchanged.
//  - Latency: a result pushed at edge k is broadcast no earlier than edge k+1.
//    There is no bypass around the FIFO. Each broadcast lasts exactly one cycle.
//    Throughput is 1 broadcast/cycle total.
//  - Simultaneous push and pop on the same FIFO: both take effect and count is unchanged.
//    A full FIFO cannot push in the same cycle it pops.
//  - FIFO pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits; full = count==DEPTH.
//  - Order: results from the same FU broadcast in push order.
//    No ordering is guaranteed across FUs.
//  - Flush (clear & validCommit), evaluated after globalReset, which has priority:
//    * at the edge, all FIFOs are emptied, rrPtr <= 0, validBroadcast <= 0, robEntry/result <= 0;
//    * results presented in the flush cycle are dropped, and no pop or broadcast is made that cycle;
//    * clear without validCommit has no effect.
//  - Reset mid-operation behaves exactly as flush; buffered results are lost.
//  - fuValid on an FU whose ready is low is ignored for that cycle (no state change).
// STRUCTURE
//  - cdb_pkg (shared package) holds:
//    * typedef struct packed {logic [ROB:0] rob; logic signed [WIDTH:0] value;} cdb_entry_t;
//    * localparam N_FU_DEFAULT;
//    * FU index constants ALU_FU=0, BRANCH_FU=1, MEM_FU=2, MUL_FU=3.
//  - Sub-module cdb_result_fifo, instantiated N_FU times:
//    * ports: clk, globalReset, flush, push, pop, din, dout, empty, full;
//    * head (dout) is always visible without a read cycle.
//  - The top contains the round-robin grant (rotate-mask + priority encode) and the output registers.
// TESTING
//  - Reset: assert globalReset 2 cycles -> validBroadcast=0, robEntry=0, result=0, fuReady=4'b1111.
//  - Single source: FU0 pushes {rob=3, val=-5} at edge k -> after edge k+1: validBroadcast=1,
//    robEntry=3, result=-5, grantIdx=0; next cycle validBroadcast=0.
//  - Round-robin: all 4 FUs push one result at the same edge (rob 0..3) -> broadcasts on 4 consecutive
//    cycles in grantIdx order 0,1,2,3; a second wave starting with rrPtr=1 goes 1,2,3,0.
//  - Backpressure/full: FU2 pushes 3 results back-to-back while FU0/1 saturate the bus ->
//    fuReady[2]=0 after 2 entries, the 3rd result is held and accepted later.
//    FU2 tags broadcast in push order, none lost or duplicated.
//  - Flush: with 5 buffered results, pulse clear=1 & validCommit=1 -> next cycle validBroadcast=0,
//    fuReady all 1, no buffered tag ever broadcast. With clear=1 & validCommit=0 -> all 5 still broadcast.
//  - Push/pop same cycle: FU1 FIFO count=1 and granted while fuValid[1]=1 -> count stays 1,
//    and the new entry broadcasts after the old one.

Source files
------------

// File: rtl/cdb_broadcast_arbiter_pkg.sv
// Shared types and constants for the common-data-bus broadcast arbiter.
package cdb_pkg;

  localparam int N_FU_DEFAULT  = 4;
  localparam int WIDTH_DEFAULT = 31;
  localparam int ROB_DEFAULT   = 2;
  localparam int DEPTH_DEFAULT = 2;

  // Functional-unit slots on the bus
  localparam int ALU_FU    = 0;
  localparam int BRANCH_FU = 1;
  localparam int MEM_FU    = 2;
  localparam int MUL_FU    = 3;

  typedef struct packed {
    logic        [ROB_DEFAULT:0]   rob;
    logic signed [WIDTH_DEFAULT:0] value;
  } cdb_entry_t;

  // Round-robin successor of a source index, wrapping at n
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdb_broadcast_arbiter_fifo.sv
// Per-FU result FIFO. Head entry is always visible on dout; flush and
// reset both empty it. Push is refused while full, even if popping.
module cdb_result_fifo
  import cdb_pkg::*;
#(
  parameter int W     = ROB_DEFAULT + WIDTH_DEFAULT + 2,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic         clk,
  input  logic         globalReset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          push_s;
  logic          pop_s;

  assign push_s = push & ~full;
  assign pop_s  = pop & ~empty;
  assign dout   = mem_q[rd_q];
  assign empty  = (cnt_q == (AW+1)'(0));
  assign full   = (cnt_q == (AW+1)'(DEPTH));

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two)
  always_ff @(posedge clk) begin
    if (globalReset || flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_s) begin
        wr_q <= wr_q + AW'(1);
      end
      if (pop_s) begin
        rd_q <= rd_q + AW'(1);
      end
      cnt_q <= cnt_q + (AW+1)'(push_s) - (AW+1)'(pop_s);
    end
  end

  // Storage write; contents are don't-care while the slot is not occupied
  always_ff @(posedge clk) begin
    if (push_s && !globalReset && !flush) begin
      mem_q[wr_q] <= din;
    end
  end

endmodule

// File: rtl/cdb_broadcast_arbiter.sv
// Common-data-bus transmitter: buffers FU results per unit and broadcasts
// one per cycle, chosen round-robin across non-empty FIFOs. N_FU must be >= 2.
module cdb_broadcast_arbiter
  import cdb_pkg::*;
#(
  parameter int N_FU  = N_FU_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int ROB   = ROB_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      globalReset,
  input  logic                      clear,
  input  logic                      validCommit,
  input  logic [N_FU-1:0]           fuValid,
  output logic [N_FU-1:0]           fuReady,
  input  logic [N_FU*(ROB+1)-1:0]   fuRob,
  input  logic [N_FU*(WIDTH+1)-1:0] fuResult,
  output logic                      validBroadcast,
  output logic [ROB:0]              robEntry,
  output logic signed [WIDTH:0]     result,
  output logic [$clog2(N_FU)-1:0]   grantIdx
);

  localparam int IDXW = $clog2(N_FU);
  localparam int EW   = ROB + WIDTH + 2;

  logic              flush_s;
  logic [N_FU-1:0]   empty_s;
  logic [N_FU-1:0]   full_s;
  logic [N_FU-1:0]   push_s;
  logic [N_FU-1:0]   pop_s;
  logic [N_FU-1:0]   req_s;
  logic [N_FU-1:0]   mask_s;
  logic [N_FU-1:0]   hi_req_s;
  logic [EW-1:0]     dout_s [N_FU];
  logic [EW-1:0]     head_s;
  logic              grant_vld_s;
  logic [IDXW-1:0]   grant_idx_s;
  logic [IDXW-1:0]   hi_idx_s;
  logic [IDXW-1:0]   lo_idx_s;

  logic [IDXW-1:0]   rr_q,   rr_d;
  logic              vb_q,   vb_d;
  logic [ROB:0]      rob_q,  rob_d;
  logic signed [WIDTH:0] res_q, res_d;
  logic [IDXW-1:0]   gidx_q, gidx_d;

  assign flush_s = clear & validCommit;
  assign fuReady = ~full_s;
  assign req_s   = ~empty_s;

  genvar gi;
  generate
    for (gi = 0; gi < N_FU; gi++) begin : g_fifo
      assign push_s[gi] = fuValid[gi] & ~full_s[gi] & ~flush_s;
      assign pop_s[gi]  = grant_vld_s & (grant_idx_s == IDXW'(gi)) & ~flush_s;

      cdb_result_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .globalReset (globalReset),
        .flush       (flush_s),
        .push        (push_s[gi]),
        .pop         (pop_s[gi]),
        .din         ({fuRob[gi*(ROB+1) +: (ROB+1)], fuResult[gi*(WIDTH+1) +: (WIDTH+1)]}),
        .dout        (dout_s[gi]),
        .empty       (empty_s[gi]),
        .full        (full_s[gi])
      );
    end
  endgenerate

  // Rotate-mask round-robin: lowest requester at/after rr_q, else lowest overall
  always_comb begin
    mask_s   = '0;
    hi_idx_s = '0;
    lo_idx_s = '0;
    for (int i = 0; i < N_FU; i++) begin
      mask_s[i] = (IDXW'(i) >= rr_q);
    end
    hi_req_s = req_s & mask_s;
    for (int i = N_FU - 1; i >= 0; i--) begin
      if (hi_req_s[i]) begin
        hi_idx_s = IDXW'(i);
      end else begin
        hi_idx_s = hi_idx_s;
      end
      if (req_s[i]) begin
        lo_idx_s = IDXW'(i);
      end else begin
        lo_idx_s = lo_idx_s;
      end
    end
    grant_vld_s = |req_s;
    if (|hi_req_s) begin
      grant_idx_s = hi_idx_s;
    end else begin
      grant_idx_s = lo_idx_s;
    end
  end

  assign head_s = dout_s[grant_idx_s];

  // Next-state of bus outputs and RR pointer; flush wipes them and suppresses the pop
  always_comb begin
    rr_d   = rr_q;
    vb_d   = vb_q;
    rob_d  = rob_q;
    res_d  = res_q;
    gidx_d = gidx_q;
    if (flush_s) begin
      rr_d   = '0;
      vb_d   = 1'b0;
      rob_d  = '0;
      res_d  = '0;
      gidx_d = '0;
    end else if (grant_vld_s) begin
      vb_d   = 1'b1;
      rob_d  = head_s[EW-1 -: (ROB+1)];
      res_d  = head_s[WIDTH:0];
      gidx_d = grant_idx_s;
      rr_d   = IDXW'(rr_next(int'(grant_idx_s), N_FU));
    end else begin
      vb_d   = 1'b0;
    end
  end

  // Output and pointer registers
  always_ff @(posedge clk) begin
    if (globalReset) begin
      rr_q   <= '0;
      vb_q   <= 1'b0;
      rob_q  <= '0;
      res_q  <= '0;
      gidx_q <= '0;
    end else begin
      rr_q   <= rr_d;
      vb_q   <= vb_d;
      rob_q  <= rob_d;
      res_q  <= res_d;
      gidx_q <= gidx_d;
    end
  end

  assign validBroadcast = vb_q;
  assign robEntry       = rob_q;
  assign result         = res_q;
  assign grantIdx       = gidx_q;

endmodule

// File: tb/tb_cdb_broadcast_arbiter.sv
// Randomised scoreboard bench for cdb_broadcast_arbiter with a queue-based reference model.
module tb_cdb_broadcast_arbiter;
  import cdb_pkg::*;

  localparam int N     = 4;
  localparam int DEPTH = 2;

  logic               clk = 1'b0;
  logic               globalReset = 1'b0;
  logic               clear = 1'b0;
  logic               validCommit = 1'b0;
  logic [N-1:0]       fuValid = '0;
  logic [N-1:0]       fuReady;
  logic [N*3-1:0]     fuRob = '0;
  logic [N*32-1:0]    fuResult = '0;
  logic               validBroadcast;
  logic [2:0]         robEntry;
  logic signed [31:0] result;
  logic [1:0]         grantIdx;

  cdb_broadcast_arbiter #(.N_FU(N), .WIDTH(31), .ROB(2), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .globalReset    (globalReset),
    .clear          (clear),
    .validCommit    (validCommit),
    .fuValid        (fuValid),
    .fuReady        (fuReady),
    .fuRob          (fuRob),
    .fuResult       (fuResult),
    .validBroadcast (validBroadcast),
    .robEntry       (robEntry),
    .result         (result),
    .grantIdx       (grantIdx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] idx;
    cdb_entry_t e;
  } bc_t;

  // reference model state
  cdb_entry_t mq [N][$];
  bc_t        exp_q [$];
  int         rr = 0;
  cdb_entry_t last_e = '0;
  bit         mon_en = 1'b0;
  int         pre_sz [N];
  int         g;
  int         j;
  cdb_entry_t e_m;

  // driver state
  cdb_entry_t src_q [N][$];
  bit         pend_v [N];
  cdb_entry_t pend_e [N];
  logic [N-1:0] rdy_seen = '0;
  bit         fl_seen = 1'b0;
  bit         drv_rst = 1'b0;
  bit         drv_clear = 1'b0;
  bit         drv_vc = 1'b0;
  bit         bp_phase = 1'b0;
  bit         bp_full_seen = 1'b0;

  int tests = 0;
  int fails = 0;

  function automatic cdb_entry_t mk(input int r, input int v);
    cdb_entry_t t;
    t.rob   = 3'(r);
    t.value = 32'(v);
    return t;
  endfunction

  // Reference model: per-FU queues, RR grant from pre-edge contents, then accept pushes
  always @(posedge clk) begin
    if (globalReset) mon_en = 1'b1;
    if (mon_en) begin
      if (globalReset || (clear && validCommit)) begin
        for (int i = 0; i < N; i++) mq[i].delete();
        rr = 0;
        last_e = '0;
      end else begin
        for (int i = 0; i < N; i++) pre_sz[i] = mq[i].size();
        g = -1;
        for (int k = 0; k < N; k++) begin
          j = (rr + k) % N;
          if (g < 0 && pre_sz[j] > 0) g = j;
        end
        if (g >= 0) begin
          e_m = mq[g].pop_front();
          exp_q.push_back({2'(g), e_m});
          last_e = e_m;
          rr = (g + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
          if (fuValid[i] && pre_sz[i] < DEPTH)
            mq[i].push_back(mk(int'(fuRob[i*3 +: 3]), int'(fuResult[i*32 +: 32])));
        end
      end
    end
  end

  // Monitor: compare bus and ready lines shortly after each edge
  always @(posedge clk) begin
    bc_t          b;
    logic [N-1:0] er;
    #1;
    if (mon_en) begin
      tests++;
      if (validBroadcast) begin
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL spurious_bcast: got valid=1 fu=%0d tag=%0d val=%0d, required valid=0", grantIdx, robEntry, result);
        end else begin
          b = exp_q.pop_front();
          if ({grantIdx, robEntry, result} !== {b.idx, b.e.rob, b.e.value}) begin
            fails++;
            $display("FAIL bcast: got fu=%0d tag=%0d val=%0d, required fu=%0d tag=%0d val=%0d",
                     grantIdx, robEntry, result, b.idx, b.e.rob, b.e.value);
          end
        end
      end else if (exp_q.size() != 0) begin
        b = exp_q.pop_front();
        fails++;
        $display("FAIL missing_bcast: got valid=0, required fu=%0d tag=%0d val=%0d", b.idx, b.e.rob, b.e.value);
      end else if (robEntry !== last_e.rob || result !== last_e.value) begin
        fails++;
        $display("FAIL idle_hold: got tag=%0d val=%0d, required tag=%0d val=%0d", robEntry, result, last_e.rob, last_e.value);
      end
      for (int i = 0; i < N; i++) er[i] = (mq[i].size() < DEPTH);
      tests++;
      if (fuReady !== er) begin
        fails++;
        $display("FAIL fuReady: got %b, required %b", fuReady, er);
      end
      if (bp_phase && !fuReady[2]) bp_full_seen = 1'b1;
    end
  end

  // One stimulus cycle: retire accepted/dropped results, load new ones, drive at negedge
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (pend_v[i] && (rdy_seen[i] || fl_seen)) pend_v[i] = 1'b0;
      if (!pend_v[i] && src_q[i].size() > 0) begin
        pend_e[i] = src_q[i].pop_front();
        pend_v[i] = 1'b1;
      end
      fuValid[i] = pend_v[i];
      if (pend_v[i]) begin
        fuRob[i*3 +: 3]      = pend_e[i].rob;
        fuResult[i*32 +: 32] = pend_e[i].value;
      end else begin
        fuRob[i*3 +: 3]      = 3'($urandom);
        fuResult[i*32 +: 32] = 32'($urandom);
      end
    end
    globalReset = drv_rst;
    clear       = drv_clear;
    validCommit = drv_vc;
    rdy_seen    = fuReady;
    fl_seen     = drv_rst || (drv_clear && drv_vc);
  endtask

  function automatic bit busy();
    bit bz = (exp_q.size() != 0);
    for (int i = 0; i < N; i++)
      if (src_q[i].size() != 0 || pend_v[i] || mq[i].size() != 0) bz = 1'b1;
    return bz;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    for (int i = 0; i < N; i++) pend_v[i] = 1'b0;

    // reset for two cycles
    drv_rst = 1'b1; tick(); tick(); drv_rst = 1'b0;
    tick();

    // single source
    src_q[ALU_FU].push_back(mk(3, -5));
    repeat (4) tick();

    // round-robin wave from rr=0, then shift rr to 1 and repeat
    for (int i = 0; i < N; i++) src_q[i].push_back(mk(i, int'($urandom)));
    repeat (7) tick();
    src_q[0].push_back(mk(7, 1234));
    repeat (3) tick();
    for (int i = 0; i < N; i++) src_q[i].push_back(mk(i, int'($urandom)));
    repeat (7) tick();

    // backpressure on MEM_FU while ALU/BRANCH saturate the bus
    bp_phase = 1'b1;
    for (int k = 0; k < 8; k++) begin
      src_q[ALU_FU].push_back(mk(k, int'($urandom)));
      src_q[BRANCH_FU].push_back(mk(k, int'($urandom)));
    end
    for (int k = 0; k < 3; k++) src_q[MEM_FU].push_back(mk(k + 4, int'($urandom)));
    repeat (24) tick();
    bp_phase = 1'b0;
    tests++;
    if (!bp_full_seen) begin
      fails++;
      $display("FAIL bp_full: got fuReady[2] never low, required low at least once");
    end

    // push and pop on the same FIFO in one cycle
    src_q[BRANCH_FU].push_back(mk(5, 111));
    src_q[BRANCH_FU].push_back(mk(6, 222));
    repeat (5) tick();

    // flush with five buffered results, then clear without validCommit
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < N; i++) src_q[i].push_back(mk(i, int'($urandom)));
      src_q[0].push_back(mk(4, int'($urandom)));
      src_q[1].push_back(mk(5, int'($urandom)));
      tick(); tick();
      drv_clear = 1'b1; drv_vc = (pass == 0);
      tick();
      drv_clear = 1'b0; drv_vc = 1'b0;
      repeat (8) tick();
    end

    // randomised traffic with occasional flush, clear-only and reset
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (src_q[i].size() < 2 && $urandom_range(0, 99) < 45)
          src_q[i].push_back(mk(int'($urandom_range(0, 7)), int'($urandom)));
      drv_rst   = ($urandom_range(0, 149) == 0);
      drv_clear = ($urandom_range(0, 14) == 0);
      drv_vc    = ($urandom_range(0, 1) == 1);
      tick();
    end
    drv_rst = 1'b0; drv_clear = 1'b0; drv_vc = 1'b0;

    // drain with a bounded wait
    guard = 0;
    while (busy() && guard < 300) begin
      tick();
      guard++;
    end
    tick();
    tests++;
    if (busy()) begin
      fails++;
      $display("FAIL drain_timeout: got outstanding=%0d, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
